// File: rtl/ctrl_pkg.sv
// Shared decode constants and the ID/EX control bundle type.
// Used by the ID stage, its decoder and the EX-side consumers.
package ctrl_pkg;

    localparam int ALUOP_W = 5;
    localparam int EXTOP_W = 6;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = 5'd0;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 5'd1;
    localparam logic [ALUOP_W-1:0] ALU_SLL   = 5'd2;
    localparam logic [ALUOP_W-1:0] ALU_SLT   = 5'd3;
    localparam logic [ALUOP_W-1:0] ALU_SLTU  = 5'd4;
    localparam logic [ALUOP_W-1:0] ALU_XOR   = 5'd5;
    localparam logic [ALUOP_W-1:0] ALU_SRL   = 5'd6;
    localparam logic [ALUOP_W-1:0] ALU_SRA   = 5'd7;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 5'd8;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 5'd9;
    localparam logic [ALUOP_W-1:0] ALU_LUI   = 5'd10;
    localparam logic [ALUOP_W-1:0] ALU_AUIPC = 5'd11;

    // One-hot immediate select {SHAMT,I,S,B,U,J}
    localparam logic [EXTOP_W-1:0] EXT_SHAMT = 6'b100000;
    localparam logic [EXTOP_W-1:0] EXT_I     = 6'b010000;
    localparam logic [EXTOP_W-1:0] EXT_S     = 6'b001000;
    localparam logic [EXTOP_W-1:0] EXT_B     = 6'b000100;
    localparam logic [EXTOP_W-1:0] EXT_U     = 6'b000010;
    localparam logic [EXTOP_W-1:0] EXT_J     = 6'b000001;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    localparam logic [2:0] DM_W  = 3'b000;
    localparam logic [2:0] DM_B  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b011;
    localparam logic [2:0] DM_H  = 3'b100;
    localparam logic [2:0] DM_HU = 3'b110;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int JT_BEQ  = 0;
    localparam int JT_BNE  = 1;
    localparam int JT_BGE  = 2;
    localparam int JT_BLT  = 3;
    localparam int JT_BGEU = 4;
    localparam int JT_BLTU = 5;
    localparam int JT_JAL  = 6;
    localparam int JT_JALR = 7;

    typedef enum logic {
        ST_RUN,
        ST_BUBBLE
    } state_e;

    typedef struct packed {
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic               regwrite;
        logic               memwrite;
        logic               memread;
        logic               alusrc;
        logic [EXTOP_W-1:0] extop;
        logic [ALUOP_W-1:0] aluop;
        logic [1:0]         wdsel;
        logic [2:0]         dmtype;
        logic [7:0]         jump_type;
        logic               illegal;
    } ctrl_t;

    // funct3 -> ALU code shared by R-type and OP-IMM; alt picks SUB/SRA
    function automatic logic [ALUOP_W-1:0] alu_of_f3(
        input logic [2:0] f3,
        input logic       alt
    );
        logic [ALUOP_W-1:0] op;
        op = ALU_ADD;
        unique case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Pure combinational RV32I decoder: instruction word to control bundle.
// Ports: instr_i in; ctrl_o bundle, has_rs2_o, without_rs_o out.
module rv32i_decoder
    import ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        has_rs2_o,
    output logic        without_rs_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f7_ok;

    assign opc   = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign f7    = instr_i[31:25];
    assign f7_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);

    always_comb begin
        ctrl_t c;
        logic  ill;
        c            = '0;
        ill          = 1'b0;
        has_rs2_o    = 1'b0;
        without_rs_o = 1'b0;
        c.rs1        = instr_i[19:15];
        c.rs2        = instr_i[24:20];
        c.rd         = instr_i[11:7];

        unique case (opc)
            OP_R: begin
                c.regwrite = 1'b1;
                has_rs2_o  = 1'b1;
                if (f7 == 7'b0000000) begin
                    c.aluop = alu_of_f3(f3, 1'b0);
                end else if (f7 == 7'b0100000 &&
                             (f3 == 3'b000 || f3 == 3'b101)) begin
                    c.aluop = alu_of_f3(f3, 1'b1);
                end else begin
                    ill = 1'b1;
                end
            end
            OP_IMM: begin
                c.regwrite = 1'b1;
                c.alusrc   = 1'b1;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    c.extop = EXT_SHAMT;
                    c.aluop = alu_of_f3(f3, (f3 == 3'b101) && instr_i[30]);
                    ill     = !f7_ok;
                end else begin
                    c.extop = EXT_I;
                    c.aluop = alu_of_f3(f3, 1'b0);
                end
            end
            OP_LOAD: begin
                c.regwrite = 1'b1;
                c.memread  = 1'b1;
                c.alusrc   = 1'b1;
                c.extop    = EXT_I;
                c.wdsel    = WD_MEM;
                unique case (f3)
                    3'b000:  c.dmtype = DM_B;
                    3'b001:  c.dmtype = DM_H;
                    3'b010:  c.dmtype = DM_W;
                    3'b100:  c.dmtype = DM_BU;
                    3'b101:  c.dmtype = DM_HU;
                    default: ill = 1'b1;
                endcase
            end
            OP_STORE: begin
                c.memwrite = 1'b1;
                c.alusrc   = 1'b1;
                c.extop    = EXT_S;
                has_rs2_o  = 1'b1;
                unique case (f3)
                    3'b000:  c.dmtype = DM_B;
                    3'b001:  c.dmtype = DM_H;
                    3'b010:  c.dmtype = DM_W;
                    default: ill = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                c.extop   = EXT_B;
                c.aluop   = ALU_SUB;
                has_rs2_o = 1'b1;
                unique case (f3)
                    3'b000:  c.jump_type[JT_BEQ]  = 1'b1;
                    3'b001:  c.jump_type[JT_BNE]  = 1'b1;
                    3'b100:  c.jump_type[JT_BLT]  = 1'b1;
                    3'b101:  c.jump_type[JT_BGE]  = 1'b1;
                    3'b110:  c.jump_type[JT_BLTU] = 1'b1;
                    3'b111:  c.jump_type[JT_BGEU] = 1'b1;
                    default: ill = 1'b1;
                endcase
            end
            OP_JAL: begin
                c.regwrite          = 1'b1;
                c.extop             = EXT_J;
                c.wdsel             = WD_PC4;
                c.jump_type[JT_JAL] = 1'b1;
                without_rs_o        = 1'b1;
            end
            OP_JALR: begin
                c.regwrite           = 1'b1;
                c.alusrc             = 1'b1;
                c.extop              = EXT_I;
                c.wdsel              = WD_PC4;
                c.jump_type[JT_JALR] = 1'b1;
                ill                  = (f3 != 3'b000);
            end
            OP_LUI: begin
                c.regwrite   = 1'b1;
                c.alusrc     = 1'b1;
                c.extop      = EXT_U;
                c.aluop      = ALU_LUI;
                without_rs_o = 1'b1;
            end
            OP_AUIPC: begin
                c.regwrite   = 1'b1;
                c.alusrc     = 1'b1;
                c.extop      = EXT_U;
                c.aluop      = ALU_AUIPC;
                without_rs_o = 1'b1;
            end
            default: ill = 1'b1;
        endcase

        // An illegal word reads no registers, so it never raises a hazard
        if (ill) begin
            c            = '0;
            c.illegal    = 1'b1;
            has_rs2_o    = 1'b0;
            without_rs_o = 1'b1;
        end else if (!c.regwrite) begin
            c.rd = 5'd0;
        end
        ctrl_o = c;
    end

endmodule

// File: rtl/decode_stage_ctrl.sv
// Registered ID stage: handshake, load-use bubble FSM, ID/EX register.
// Optional perf counters enabled by macro DECODE_PERF_CNT_EN.
// Ports: clk/rst; if_* request side; flush; ex_* registered bundle;
//        perf_bubbles/perf_flushes (zero unless counters enabled).
module decode_stage_ctrl
    import ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid,
    output logic               if_ready,
    input  logic [31:0]        if_instr,
    input  logic [XLEN-1:0]    if_pc,
    input  logic               flush,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [XLEN-1:0]    ex_pc,
    output logic [4:0]         ex_rs1,
    output logic [4:0]         ex_rs2,
    output logic [4:0]         ex_rd,
    output logic               ex_regwrite,
    output logic               ex_memwrite,
    output logic               ex_memread,
    output logic               ex_alusrc,
    output logic [EXTOP_W-1:0] ex_extop,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [1:0]         ex_wdsel,
    output logic [2:0]         ex_dmtype,
    output logic [7:0]         ex_jump_type,
    output logic               ex_illegal,
    output logic [CNT_W-1:0]   perf_bubbles,
    output logic [CNT_W-1:0]   perf_flushes
);

    ctrl_t           dec;
    logic            has_rs2;
    logic            without_rs;
    ctrl_t           ctrl_q, ctrl_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    state_e          state_q, state_d;
    logic            adv, hazard, accept, bubble;

    rv32i_decoder u_dec (
        .instr_i      (if_instr),
        .ctrl_o       (dec),
        .has_rs2_o    (has_rs2),
        .without_rs_o (without_rs)
    );

    assign adv = !valid_q || ex_ready;

    assign hazard = valid_q && ctrl_q.memread && (ctrl_q.rd != 5'd0) &&
                    if_valid && !without_rs &&
                    ((dec.rs1 == ctrl_q.rd) ||
                     (has_rs2 && dec.rs2 == ctrl_q.rd));

    // Hazard needs a live load in EX, so it is always low in BUBBLE;
    // that state therefore accepts without an extra state term here.
    assign if_ready = !rst && adv && !hazard && !flush;
    assign accept   = if_valid && if_ready;
    assign bubble   = (state_q == ST_RUN) && hazard && adv &&
                      !flush && !rst;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else if (accept) begin
            valid_d = 1'b1;
            ctrl_d  = dec;
            pc_d    = if_pc;
            state_d = ST_RUN;
        end else if (adv) begin
            valid_d = 1'b0;
            state_d = bubble ? ST_BUBBLE : ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc_q    <= pc_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_pc        = pc_q;
    assign ex_rs1       = ctrl_q.rs1;
    assign ex_rs2       = ctrl_q.rs2;
    assign ex_rd        = ctrl_q.rd;
    assign ex_regwrite  = ctrl_q.regwrite;
    assign ex_memwrite  = ctrl_q.memwrite;
    assign ex_memread   = ctrl_q.memread;
    assign ex_alusrc    = ctrl_q.alusrc;
    assign ex_extop     = ctrl_q.extop;
    assign ex_aluop     = ctrl_q.aluop;
    assign ex_wdsel     = ctrl_q.wdsel;
    assign ex_dmtype    = ctrl_q.dmtype;
    assign ex_jump_type = ctrl_q.jump_type;
    assign ex_illegal   = ctrl_q.illegal;

`ifdef DECODE_PERF_CNT_EN
    logic [CNT_W-1:0] bub_q, bub_d;
    logic [CNT_W-1:0] fl_q, fl_d;

    always_comb begin
        bub_d = bub_q;
        fl_d  = fl_q;
        if (bubble && bub_q != '1) begin
            bub_d = bub_q + 1'b1;
        end
        // A flush counts once if it kills the held or the offered word
        if (flush && (valid_q || if_valid) && fl_q != '1) begin
            fl_d = fl_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bub_q <= '0;
            fl_q  <= '0;
        end else begin
            bub_q <= bub_d;
            fl_q  <= fl_d;
        end
    end

    assign perf_bubbles = bub_q;
    assign perf_flushes = fl_q;
`else
    assign perf_bubbles = '0;
    assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_decode_stage_ctrl.sv
// Directed self-checking bench for decode_stage_ctrl.
// Covers decode, load-use bubble, stall, flush, illegal and reset.
module tb_decode_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_regwrite, ex_memwrite, ex_memread, ex_alusrc;
    logic [5:0]  ex_extop;
    logic [4:0]  ex_aluop;
    logic [1:0]  ex_wdsel;
    logic [2:0]  ex_dmtype;
    logic [7:0]  ex_jump_type;
    logic        ex_illegal;
    logic [31:0] perf_bubbles, perf_flushes;

    int checks   = 0;
    int failures = 0;

`ifdef DECODE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    decode_stage_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_pc        (ex_pc),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .ex_memwrite  (ex_memwrite),
        .ex_memread   (ex_memread),
        .ex_alusrc    (ex_alusrc),
        .ex_extop     (ex_extop),
        .ex_aluop     (ex_aluop),
        .ex_wdsel     (ex_wdsel),
        .ex_dmtype    (ex_dmtype),
        .ex_jump_type (ex_jump_type),
        .ex_illegal   (ex_illegal),
        .perf_bubbles (perf_bubbles),
        .perf_flushes (perf_flushes)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pexp(input int n);
        return PERF ? n : 0;
    endfunction

    initial begin
        rst      = 1'b1;
        if_valid = 1'b0;
        if_instr = 32'h0;
        if_pc    = 32'h0;
        flush    = 1'b0;
        ex_ready = 1'b0;
        tick();
        tick();
        chk("rst_if_ready", if_ready, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_pc", ex_pc, 0);
        chk("rst_aluop", ex_aluop, 0);
        chk("rst_bubbles", perf_bubbles, 0);

        rst      = 1'b0;
        ex_ready = 1'b1;
        #1;
        chk("idle_if_ready", if_ready, 1);

        // add x3,x1,x2
        if_valid = 1'b1;
        if_instr = 32'h002081B3;
        if_pc    = 32'h100;
        tick();
        chk("add_valid", ex_valid, 1);
        chk("add_regwrite", ex_regwrite, 1);
        chk("add_aluop", ex_aluop, 5'd0);
        chk("add_rd", ex_rd, 3);
        chk("add_rs1", ex_rs1, 1);
        chk("add_rs2", ex_rs2, 2);
        chk("add_illegal", ex_illegal, 0);
        chk("add_pc", ex_pc, 32'h100);
        chk("add_alusrc", ex_alusrc, 0);

        // lw x5,0(x1)
        if_instr = 32'h0000A283;
        if_pc    = 32'h104;
        tick();
        chk("lw_valid", ex_valid, 1);
        chk("lw_memread", ex_memread, 1);
        chk("lw_rd", ex_rd, 5);
        chk("lw_wdsel", ex_wdsel, 2'b01);
        chk("lw_extop", ex_extop, 6'b010000);
        chk("lw_alusrc", ex_alusrc, 1);
        chk("lw_dmtype", ex_dmtype, 3'b000);

        // add x6,x5,x5 depends on the load
        if_instr = 32'h00528333;
        if_pc    = 32'h108;
        #1;
        chk("hz_if_ready", if_ready, 0);
        tick();
        chk("bubble_valid", ex_valid, 0);
        chk("bubble_if_ready", if_ready, 1);
        tick();
        chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_rd", ex_rd, 6);
        chk("lu_add_pc", ex_pc, 32'h108);
        chk("perf_bub1", perf_bubbles, pexp(1));

        // sub x7,x1,x2 offered while EX stalls
        ex_ready = 1'b0;
        if_instr = 32'h402083B3;
        if_pc    = 32'h10C;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", ex_valid, 1);
            chk("stall_rd", ex_rd, 6);
            chk("stall_pc", ex_pc, 32'h108);
            chk("stall_if_ready", if_ready, 0);
        end
        ex_ready = 1'b1;
        #1;
        chk("unstall_if_ready", if_ready, 1);
        tick();
        chk("sub_pc", ex_pc, 32'h10C);
        chk("sub_rd", ex_rd, 7);
        chk("sub_aluop", ex_aluop, 5'd1);
        chk("sub_illegal", ex_illegal, 0);
        if_valid = 1'b0;
        tick();
        chk("drain_valid", ex_valid, 0);

        // flush during a load-use bubble
        if_valid = 1'b1;
        if_instr = 32'h0000A283;
        if_pc    = 32'h200;
        tick();
        chk("lw2_memread", ex_memread, 1);
        if_instr = 32'h00528333;
        if_pc    = 32'h204;
        tick();
        chk("bubble2_valid", ex_valid, 0);
        flush = 1'b1;
        #1;
        chk("flush_if_ready", if_ready, 0);
        tick();
        chk("flush_valid", ex_valid, 0);
        flush = 1'b0;
        #1;
        chk("post_flush_ready", if_ready, 1);
        tick();
        chk("refetch_valid", ex_valid, 1);
        chk("refetch_pc", ex_pc, 32'h204);
        chk("perf_bub2", perf_bubbles, pexp(2));
        chk("perf_fl1", perf_flushes, pexp(1));

        // flush while EX is stalled
        if_valid = 1'b0;
        ex_ready = 1'b0;
        flush    = 1'b1;
        tick();
        chk("flush_stall_valid", ex_valid, 0);
        chk("perf_fl2", perf_flushes, pexp(2));
        flush    = 1'b0;
        ex_ready = 1'b1;

        // illegal encodings
        if_valid = 1'b1;
        if_instr = 32'hFFFFFFFF;
        if_pc    = 32'h300;
        tick();
        chk("ffff_valid", ex_valid, 1);
        chk("ffff_illegal", ex_illegal, 1);
        chk("ffff_regwrite", ex_regwrite, 0);
        chk("ffff_memwrite", ex_memwrite, 0);
        chk("ffff_memread", ex_memread, 0);
        if_instr = 32'h042081B3;
        tick();
        chk("f7bad_illegal", ex_illegal, 1);
        chk("f7bad_regwrite", ex_regwrite, 0);
        chk("f7bad_rd", ex_rd, 0);

        // sw x2,4(x1)
        if_instr = 32'h0020A223;
        tick();
        chk("sw_memwrite", ex_memwrite, 1);
        chk("sw_rd", ex_rd, 0);
        chk("sw_extop", ex_extop, 6'b001000);
        chk("sw_rs2", ex_rs2, 2);
        chk("sw_illegal", ex_illegal, 0);

        // bne x1,x2,0
        if_instr = 32'h00209063;
        tick();
        chk("bne_jump", ex_jump_type, 8'h02);
        chk("bne_extop", ex_extop, 6'b000100);
        chk("bne_regwrite", ex_regwrite, 0);

        // jal x1,8
        if_instr = 32'h008000EF;
        if_pc    = 32'h310;
        tick();
        chk("jal_jump", ex_jump_type, 8'h40);
        chk("jal_wdsel", ex_wdsel, 2'b10);
        chk("jal_rd", ex_rd, 1);
        chk("jal_extop", ex_extop, 6'b000001);

        // reset while stalled
        ex_ready = 1'b0;
        if_instr = 32'h000124B7;
        if_pc    = 32'h314;
        tick();
        chk("hold_valid", ex_valid, 1);
        chk("hold_pc", ex_pc, 32'h310);
        rst = 1'b1;
        tick();
        chk("mrst_valid", ex_valid, 0);
        chk("mrst_pc", ex_pc, 0);
        chk("mrst_rd", ex_rd, 0);
        chk("mrst_jump", ex_jump_type, 0);
        chk("mrst_if_ready", if_ready, 0);
        chk("mrst_bubbles", perf_bubbles, 0);
        chk("mrst_flushes", perf_flushes, 0);
        rst      = 1'b0;
        if_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
